// File: rtl/measurement_shot_controller.sv
// Measurement shot controller: loads amplitudes into the sampler weight bus, fires
// LFSR-randomised shots, bins the returned basis indices and streams the histogram out.
module measurement_shot_controller #(
    parameter int unsigned NUM_QUBIT    = 4,
    parameter int unsigned WEIGHT_WIDTH = 32,
    parameter int unsigned SHOT_WIDTH   = 16,
    parameter logic [31:0] SEED         = 32'hACE12468,
    localparam int unsigned NUM_WEIGHT  = 2 ** NUM_QUBIT
) (
    input  logic                               clk,
    input  logic                               rstnn,
    input  logic                               start,
    input  logic [SHOT_WIDTH-1:0]              num_shots,
    input  logic [WEIGHT_WIDTH-1:0]            amp_in,
    input  logic                               amp_valid,
    output logic                               amp_ready,
    output logic [NUM_WEIGHT*WEIGHT_WIDTH-1:0] weight,
    output logic                               weight_stb,
    output logic [31:0]                        random_num,
    input  logic [NUM_QUBIT-1:0]               smp_out,
    input  logic                               smp_out_stb,
    output logic [NUM_QUBIT-1:0]               hist_idx,
    output logic [SHOT_WIDTH-1:0]              hist_count,
    output logic                               hist_valid,
    input  logic                               hist_ready,
    output logic                               busy,
    output logic                               done
);
    localparam logic [NUM_QUBIT-1:0] LastIdx  = NUM_QUBIT'(NUM_WEIGHT - 1);
    localparam logic [31:0]          LfsrTaps = 32'h80200003;

    typedef enum logic [2:0] {StIdle, StLoad, StShoot, StWait, StDump} state_e;

    state_e                state_q;
    logic [SHOT_WIDTH-1:0] num_shots_q;
    logic [SHOT_WIDTH-1:0] shot_cnt_q;
    logic [NUM_QUBIT-1:0]  load_cnt_q;
    logic [SHOT_WIDTH-1:0] bin_q [NUM_WEIGHT];

    logic [31:0]           lfsr_next;
    logic [SHOT_WIDTH-1:0] shot_cnt_inc;
    logic [SHOT_WIDTH-1:0] bin_inc;
    logic [NUM_QUBIT-1:0]  hist_idx_inc;

    // random_num is the LFSR state itself, so it always shows the value for the next shot.
    always_comb begin
        lfsr_next    = (random_num >> 1) ^ (random_num[0] ? LfsrTaps : 32'h0);
        shot_cnt_inc = shot_cnt_q + 1'b1;
        bin_inc      = bin_q[smp_out] + 1'b1;
        hist_idx_inc = hist_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q     <= StIdle;
            num_shots_q <= '0;
            shot_cnt_q  <= '0;
            load_cnt_q  <= '0;
            for (int i = 0; i < NUM_WEIGHT; i++) bin_q[i] <= '0;
            amp_ready   <= 1'b0;
            weight      <= '0;
            weight_stb  <= 1'b0;
            random_num  <= SEED;
            hist_idx    <= '0;
            hist_count  <= '0;
            hist_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            weight_stb <= 1'b0;
            done       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (num_shots != '0) begin
                            num_shots_q <= num_shots;
                            shot_cnt_q  <= '0;
                            load_cnt_q  <= '0;
                            for (int i = 0; i < NUM_WEIGHT; i++) bin_q[i] <= '0;
                            amp_ready   <= 1'b1;
                            busy        <= 1'b1;
                            state_q     <= StLoad;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (amp_valid) begin
                        weight[WEIGHT_WIDTH*load_cnt_q +: WEIGHT_WIDTH] <= amp_in;
                        load_cnt_q <= load_cnt_q + 1'b1;
                        if (load_cnt_q == LastIdx) begin
                            amp_ready  <= 1'b0;
                            weight_stb <= 1'b1;
                            state_q    <= StShoot;
                        end
                    end
                end
                StShoot: begin
                    random_num <= lfsr_next;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (smp_out_stb) begin
                        bin_q[smp_out] <= bin_inc;
                        shot_cnt_q     <= shot_cnt_inc;
                        if (shot_cnt_inc == num_shots_q) begin
                            // Bin 0 may be the one incremented on this very edge.
                            hist_valid <= 1'b1;
                            hist_idx   <= '0;
                            hist_count <= (smp_out == '0) ? bin_inc : bin_q[0];
                            state_q    <= StDump;
                        end else begin
                            weight_stb <= 1'b1;
                            state_q    <= StShoot;
                        end
                    end
                end
                StDump: begin
                    if (hist_ready) begin
                        if (hist_idx == LastIdx) begin
                            hist_valid <= 1'b0;
                            hist_idx   <= '0;
                            hist_count <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            hist_idx   <= hist_idx_inc;
                            hist_count <= bin_q[hist_idx_inc];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
